// File: rtl/ucsbece154b_line_refill.sv
// ucsbece154b_line_refill
// Instruction-line refill engine. It accepts one refill request, issues a
// single burst read for the aligned line and captures the returned beats in a
// line buffer. The words go to the fetch FIFO in beat order. Draining is
// cut-through: a word may leave as soon as the cycle after its beat arrives.
//
// Handshakes:
//   req_valid_i/req_ready_o : a request is taken on a cycle where both are 1.
//                             The requester holds req_valid_i and req_addr_i
//                             until that cycle.
//   mem_req_o/mem_gnt_i     : mem_req_o and mem_addr_o hold steady until a
//                             cycle with mem_gnt_i=1. Beats (mem_rvalid_i)
//                             cannot be stalled and count only in XFER.
//   fifo_push_o/fifo_full_i : a push happens on any cycle with fifo_push_o=1.
//                             The block never pushes while fifo_full_i=1.
module ucsbece154b_line_refill #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  req_ready_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  fifo_push_o,
    input  logic                  fifo_full_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int IW  = $clog2(BLOCK_WORDS);
    localparam int CW  = IW + 1;
    localparam int OFS = $clog2(DATA_WIDTH / 8) + IW;

    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0]         CNT_LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_e;

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;

    logic                  beat_we;
    logic                  push;
    logic [DATA_WIDTH-1:0] line_buf_q [BLOCK_WORDS];

    // Next-state logic: request accept, grant wait, and independent
    // receive/push counters during the burst.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        beat_we  = 1'b0;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i & ~OFS_MASK;
                    rx_cnt_d = '0;
                    tx_cnt_d = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // Beats past the end of the line have nowhere to go; drop them.
                beat_we = mem_rvalid_i && (rx_cnt_q < CNT_FULL);
                if (beat_we) begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
                // Only words already in the buffer are pushable: no rdata bypass.
                push = (tx_cnt_q < rx_cnt_q) && !fifo_full_i;
                if (push) begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                    if (tx_cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state; reset abandons any line in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // Line buffer capture; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (beat_we) begin
            line_buf_q[rx_cnt_q[IW-1:0]] <= mem_rdata_i;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_addr_o  = addr_q;
    assign fifo_push_o = push;
    assign fifo_data_o = line_buf_q[tx_cnt_q[IW-1:0]];
    assign done_o      = push && (tx_cnt_q == CNT_LAST);

endmodule

// File: tb/tb_ucsbece154b_line_refill.sv
// Directed bench for ucsbece154b_line_refill with BLOCK_WORDS=4, 32-bit data.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A push monitor records every FIFO push with its cycle number.
module tb_ucsbece154b_line_refill;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] fifo_data_o;
  logic        fifo_push_o;
  logic        fifo_full_i;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_full_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  int          done_cyc_q[$];

  ucsbece154b_line_refill #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BLOCK_WORDS(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .fifo_data_o(fifo_data_o),
    .fifo_push_o(fifo_push_o),
    .fifo_full_i(fifo_full_i),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- push monitor ----------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (fifo_push_o) begin
        got_q.push_back(fifo_data_o);
        got_cyc_q.push_back(cyc);
        if (fifo_full_i) push_full_cnt++;
      end
      if (done_o) done_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    done_cyc_q.delete();
    push_full_cnt = 0;
  endtask

  // Presents a request until accepted, then runs the grant phase with
  // gnt_dly ungranted REQ cycles. Optionally drives stray beats in REQ.
  task automatic issue_req(input logic [31:0] addr, input int gnt_dly, input bit stray,
                           input bit keep_valid, input logic [31:0] next_addr,
                           output int acc_cyc, output int n_req,
                           output logic [31:0] first_addr, output bit stable, output bit to);
    int t;
    to = 0; n_req = 0; stable = 1; t = 0; first_addr = '0;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    @(negedge clk_i);
    while (!req_ready_o && t < 200) begin
      step();
      @(negedge clk_i);
      t++;
    end
    if (!req_ready_o) to = 1;
    acc_cyc = cyc;
    step();
    req_valid_i = keep_valid;
    req_addr_i  = next_addr;
    for (int i = 0; i <= gnt_dly; i++) begin
      mem_gnt_i    = (i == gnt_dly);
      mem_rvalid_i = stray;
      mem_rdata_i  = 32'hDEAD_0000 + 32'(i);
      @(negedge clk_i);
      if (mem_req_o) n_req++;
      if (i == 0) first_addr = mem_addr_o;
      else if (mem_addr_o !== first_addr) stable = 0;
      step();
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  // Sends 4 beats d0..d0+3 on consecutive cycles from the first XFER cycle;
  // full_pat[i] drives fifo_full_i in XFER cycle i. Returns after done_o.
  task automatic xfer(input logic [31:0] d0, input logic [15:0] full_pat,
                      output int start_cyc, output bit ready_seen, output bit to);
    int  i;
    bit  done_seen;
    i = 0; done_seen = 0; ready_seen = 0;
    start_cyc = cyc;
    while (!done_seen && i < 100) begin
      mem_rvalid_i = (i < 4);
      mem_rdata_i  = d0 + 32'(i);
      fifo_full_i  = (i < 16) ? full_pat[i] : 1'b0;
      @(negedge clk_i);
      if (done_o) done_seen = 1;
      if (req_ready_o) ready_seen = 1;
      step();
      i++;
    end
    mem_rvalid_i = 1'b0;
    fifo_full_i  = 1'b0;
    to = !done_seen;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    #2;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req_o); end
    checks++; if (fifo_push_o !== 1'b0) begin errors++; $display("FAIL reset_push: got %b exp 0", fifo_push_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_addr_o); end
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int acc, nreq, s; logic [31:0] fa; bit stb, to1, to2, rdy;
    clear_log();
    issue_req(32'h0000_104C, 1, 0, 0, 32'h0, acc, nreq, fa, stb, to1);
    checks++; if (to1) begin errors++; $display("FAIL basic_accept: got timeout exp accept"); end
    checks++; if (fa !== 32'h0000_1040) begin errors++; $display("FAIL basic_addr: got %h exp 00001040", fa); end
    checks++; if (nreq != 2) begin errors++; $display("FAIL basic_req_cycles: got %0d exp 2", nreq); end
    checks++; if (!stb) begin errors++; $display("FAIL basic_addr_stable: got unstable exp stable"); end
    xfer(32'hA0, 16'h0000, s, rdy, to2);
    checks++; if (to2) begin errors++; $display("FAIL basic_done_timeout: got no done exp done"); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_push_count: got %0d exp 4", got_q.size()); end
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hA0 + 32'(k));
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL basic_data[%0d]: got %h exp %h", k, got_q[k], exp_q[k]); end
      checks++; if (got_cyc_q[k] != s + 1 + k) begin errors++; $display("FAIL basic_push_cycle[%0d]: got %0d exp %0d", k, got_cyc_q[k], s + 1 + k); end
    end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d exp 1", done_cyc_q.size()); end
    else begin
      checks++; if (done_cyc_q[0] != s + 4) begin errors++; $display("FAIL basic_done_cycle: got %0d exp %0d", done_cyc_q[0], s + 4); end
    end
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b exp 1", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b exp 0", busy_o); end
    step();
  endtask

  task automatic test_full_stall();
    int acc, nreq, s; logic [31:0] fa; bit stb, to1, to2, rdy;
    clear_log();
    issue_req(32'h0000_1040, 0, 0, 0, 32'h0, acc, nreq, fa, stb, to1);
    xfer(32'hA0, 16'h000F, s, rdy, to2);
    checks++; if (to2) begin errors++; $display("FAIL stall_done_timeout: got no done exp done"); end
    checks++; if (push_full_cnt != 0) begin errors++; $display("FAIL stall_push_while_full: got %0d exp 0", push_full_cnt); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL stall_push_count: got %0d exp 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL stall_data[%0d]: got %h exp %h", k, got_q[k], 32'hA0 + 32'(k)); end
      checks++; if (got_cyc_q[k] != s + 4 + k) begin errors++; $display("FAIL stall_push_cycle[%0d]: got %0d exp %0d", k, got_cyc_q[k], s + 4 + k); end
    end
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 7) begin
      errors++; $display("FAIL stall_done_cycle: got %0d entries exp one at %0d", done_cyc_q.size(), s + 7);
    end
    step();
  endtask

  task automatic test_gnt_delay();
    int acc, nreq, s; logic [31:0] fa; bit stb, to1, to2, rdy;
    clear_log();
    issue_req(32'h0000_5008, 5, 1, 0, 32'h0, acc, nreq, fa, stb, to1);
    checks++; if (nreq != 6) begin errors++; $display("FAIL gnt_req_cycles: got %0d exp 6", nreq); end
    checks++; if (fa !== 32'h0000_5000) begin errors++; $display("FAIL gnt_addr: got %h exp 00005000", fa); end
    checks++; if (!stb) begin errors++; $display("FAIL gnt_addr_stable: got unstable exp stable"); end
    checks++; if (dut.rx_cnt_q !== 3'd0) begin errors++; $display("FAIL gnt_rx_cnt: got %0d exp 0", dut.rx_cnt_q); end
    xfer(32'hA0, 16'h0000, s, rdy, to2);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL gnt_push_count: got %0d exp 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL gnt_data[%0d]: got %h exp %h", k, got_q[k], 32'hA0 + 32'(k)); end
    end
    step();
  endtask

  task automatic test_full_toggle();
    int acc, nreq, s; logic [31:0] fa; bit stb, to1, to2, rdy;
    int exp_cyc[4];
    clear_log();
    issue_req(32'h0000_1040, 0, 0, 0, 32'h0, acc, nreq, fa, stb, to1);
    // full = 1,0,1,0 in XFER cycles 0..3, then 0
    xfer(32'hA0, 16'h0005, s, rdy, to2);
    exp_cyc[0] = s + 1; exp_cyc[1] = s + 3; exp_cyc[2] = s + 4; exp_cyc[3] = s + 5;
    checks++; if (push_full_cnt != 0) begin errors++; $display("FAIL toggle_push_while_full: got %0d exp 0", push_full_cnt); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL toggle_push_count: got %0d exp 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL toggle_data[%0d]: got %h exp %h", k, got_q[k], 32'hA0 + 32'(k)); end
      checks++; if (got_cyc_q[k] != exp_cyc[k]) begin errors++; $display("FAIL toggle_push_cycle[%0d]: got %0d exp %0d", k, got_cyc_q[k], exp_cyc[k]); end
    end
    step();
  endtask

  task automatic test_async_reset();
    int acc, nreq, s; logic [31:0] fa; bit stb, to1, to2, rdy;
    clear_log();
    issue_req(32'h0000_3000, 0, 0, 0, 32'h0, acc, nreq, fa, stb, to1);
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hA0 + 32'(i);
      step();
    end
    mem_rvalid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL arst_mem_req: got %b exp 0", mem_req_o); end
    checks++; if (fifo_push_o !== 1'b0) begin errors++; $display("FAIL arst_push: got %b exp 0", fifo_push_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b exp 0", busy_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b exp 1", req_ready_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL arst_addr: got %h exp 0", mem_addr_o); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL arst_pre_pushes: got %0d exp 2", got_q.size()); end
    step();
    rst_i = 1'b0;
    step();
    clear_log();
    issue_req(32'h0000_2000, 0, 0, 0, 32'h0, acc, nreq, fa, stb, to1);
    checks++; if (fa !== 32'h0000_2000) begin errors++; $display("FAIL arst_new_addr: got %h exp 00002000", fa); end
    xfer(32'hB0, 16'h0000, s, rdy, to2);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL arst_new_count: got %0d exp 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== 32'hB0 + 32'(k)) begin errors++; $display("FAIL arst_new_data[%0d]: got %h exp %h", k, got_q[k], 32'hB0 + 32'(k)); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, nreq, s; logic [31:0] fa1, fa2; bit stb, to1, to2, rdy;
    clear_log();
    issue_req(32'h0000_1000, 0, 0, 1, 32'h0000_2000, acc1, nreq, fa1, stb, to1);
    xfer(32'hC0, 16'h0000, s, rdy, to2);
    checks++; if (rdy) begin errors++; $display("FAIL b2b_ready_while_busy: got 1 exp 0"); end
    issue_req(32'h0000_2000, 0, 0, 0, 32'h0, acc2, nreq, fa2, stb, to1);
    checks++; if (fa1 !== 32'h0000_1000) begin errors++; $display("FAIL b2b_addr1: got %h exp 00001000", fa1); end
    checks++; if (fa2 !== 32'h0000_2000) begin errors++; $display("FAIL b2b_addr2: got %h exp 00002000", fa2); end
    checks++; if (done_cyc_q.size() < 1 || acc2 != done_cyc_q[0] + 1) begin
      errors++; $display("FAIL b2b_accept_cycle: got %0d exp done+1", acc2);
    end
    xfer(32'hD0, 16'h0000, s, rdy, to2);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hC0 + 32'(k));
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hD0 + 32'(k));
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL b2b_push_count: got %0d exp 8", got_q.size()); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_data[%0d]: got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (done_cyc_q.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d exp 2", done_cyc_q.size()); end
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    fifo_full_i  = 1'b0;
    step();
    test_reset();
    test_basic();
    test_full_stall();
    test_gnt_delay();
    test_full_toggle();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
